// File: rtl/ar_incoming_request_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ar_incoming_request_buffer
//  Purpose  : Circular-buffer FIFO holding incoming AXI AR requests ahead of
//             the ordering unit. The head entry is presented combinationally.
//             There is no bypass, and the payload (including the ID) passes
//             through unmodified.
//  Revision : 1.0  initial release
// ============================================================================
module ar_incoming_request_buffer #(
   parameter int ID_WIDTH    = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int SIZE_WIDTH  = 3,
   parameter int BURST_WIDTH = 2,
   parameter int QOS_WIDTH   = 4,
   parameter int DEPTH       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ar_in_valid,
   output logic                     ar_in_ready,
   input  logic [ID_WIDTH-1:0]      ar_in_id,
   input  logic [ADDR_WIDTH-1:0]    ar_in_addr,
   input  logic [LEN_WIDTH-1:0]     ar_in_len,
   input  logic [SIZE_WIDTH-1:0]    ar_in_size,
   input  logic [BURST_WIDTH-1:0]   ar_in_burst,
   input  logic [QOS_WIDTH-1:0]     ar_in_qos,
   output logic                     ar_out_valid,
   input  logic                     ar_out_ready,
   output logic [ID_WIDTH-1:0]      ar_out_id,
   output logic [ADDR_WIDTH-1:0]    ar_out_addr,
   output logic [LEN_WIDTH-1:0]     ar_out_len,
   output logic [SIZE_WIDTH-1:0]    ar_out_size,
   output logic [BURST_WIDTH-1:0]   ar_out_burst,
   output logic [QOS_WIDTH-1:0]     ar_out_qos,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH
                          + BURST_WIDTH + QOS_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Entry storage deliberately has no reset; ar_out_valid hides stale slots
   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] head_entry;

   // Status decode from the registered occupancy only. The ready signal
   // never looks at ar_out_ready, so a full buffer cannot pass a request through.
   always_comb begin
      full         = (count_q == DEPTH_C);
      empty        = (count_q == '0);
      ar_in_ready  = ~full;
      ar_out_valid = ~empty;
      count        = count_q;
      push         = ar_in_valid & ~full;
      pop          = ~empty & ar_out_ready;
   end

   // Pointer and occupancy next-state. Pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state. Reset discards every stored entry and overrides push/pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload write at the write pointer. It is suppressed while in reset.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   // Pack the incoming payload and unpack the head entry for the ordering unit
   always_comb begin
      in_entry   = {ar_in_id, ar_in_addr, ar_in_len, ar_in_size, ar_in_burst, ar_in_qos};
      head_entry = mem_q[rd_ptr_q];
      {ar_out_id, ar_out_addr, ar_out_len, ar_out_size, ar_out_burst, ar_out_qos} = head_entry;
   end

endmodule
`default_nettype wire

// File: doc/ar_incoming_request_buffer.md
AR_INCOMING_REQUEST_BUFFER -- requirements
Module: ar_incoming_request_buffer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 ID_WIDTH 32 original AR ID width; ADDR_WIDTH 32 address width; LEN_WIDTH 8 burst length; SIZE_WIDTH 3 beat size; BURST_WIDTH 2 burst type; QOS_WIDTH 4 QoS; DEPTH 8 entries, power of two, >= 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous, active-low reset
 ar_in_valid  in  1  master AR request valid
 ar_in_ready  out  1  buffer can accept
 ar_in_id/addr/len/size/burst/qos  in  *_WIDTH  AR payload from master
 ar_out_valid  out  1  head entry available to ordering unit
 ar_out_ready  in  1  ordering unit accepts head
 ar_out_id/addr/len/size/burst/qos  out  *_WIDTH  head-entry payload, ID unmodified
 count  out  $clog2(DEPTH)+1  entries stored
 full  out  1  count == DEPTH
 empty  out  1  count == 0
REQ-003 Clock is clk; reset is rst, synchronous, active-low; no other clock or reset.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH entries, each holding {id, addr, len, size, burst, qos}.
REQ-005 Write pointer and read pointer SHALL each be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 by natural overflow.
REQ-006 push = ar_in_valid & ar_in_ready; pop = ar_out_valid & ar_out_ready.
REQ-007 ar_in_ready SHALL equal ~full; it SHALL NOT depend combinationally on ar_out_ready (no pass-through when full).
REQ-008 ar_out_valid SHALL equal ~empty.
REQ-009 ar_out_* SHALL be driven combinationally from the entry at the read pointer; fields SHALL stay stable while ar_out_valid=1 and no pop.
REQ-010 On push the payload SHALL be written at the write pointer and the write pointer incremented on the same edge.
REQ-011 On pop the read pointer SHALL increment on the same edge.
REQ-012 count next = count + push - pop; push and pop together SHALL leave count unchanged and advance both pointers.
REQ-013 Latency: an entry pushed at edge N SHALL appear on ar_out with ar_out_valid=1 in the cycle after edge N (one-cycle fall-through minimum), no bypass.
REQ-014 Order SHALL be strict FIFO; IDs are neither modified nor reordered.
REQ-015 When empty, push with ar_out_ready=1 SHALL NOT pop in that cycle.
REQ-016 When full, pop and ar_in_valid=1 in the same cycle SHALL NOT push (ar_in_ready=0); the freed slot is usable from the next cycle.
REQ-017 full and empty SHALL be decoded from registered count, never both 1.
REQ-018 ar_in_valid with ar_in_ready=0 SHALL leave all state unchanged; the master holds its request.
REQ-019 Storage contents are not reset; unread entries SHALL never be presented because ar_out_valid gates them.

Reset
REQ-020 On a clk edge with rst=0: pointers=0, count=0, empty=1, full=0, ar_in_ready=1, ar_out_valid=0.
REQ-021 Reset mid-operation SHALL discard all stored entries; the first push after reset release SHALL be the first entry output.
REQ-022 push and pop SHALL be ignored on any edge where rst=0.

Verification
REQ-023 Reset, then push ID 0x11 addr 0x1000 len 3 with ar_out_ready=0 -> next cycle ar_out_valid=1, ar_out_id=0x11, ar_out_addr=0x1000, count=1.
REQ-024 Push IDs 1..8 with ar_out_ready=0 -> count=8, full=1, ar_in_ready=0; ninth request (ID 9) held, not stored; raise ar_out_ready -> outputs IDs 1..8 in order, then ID 9.
REQ-025 Full buffer, ar_in_valid=1 and ar_out_ready=1 same cycle -> pop only, count 8->7; ar_in_ready=1 next cycle, push then accepted.
REQ-026 count=3, continuous push and pop for 20 cycles -> count stays 3, pointers wrap at least twice, output order equals input order.
REQ-027 Empty buffer, push ID 0x5 with ar_out_ready=1 -> no pop that cycle; pop next cycle, count returns to 0, empty=1.
REQ-028 count=5, assert rst=0 one cycle -> count=0, empty=1, ar_out_valid=0; next push ID 0xA appears as head.
